// File: rtl/ofm_wb_pkg.sv
// Shared types and helpers for the OFM write-back path: FSM states, packing
// constants and the layer-size calculation done when a job starts.
package ofm_wb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } wb_state_t;

    localparam int CH_PER_CAPTURE    = 16;
    localparam int BYTES_PER_WORD    = 4;
    localparam int WORDS_PER_CAPTURE = 4;
    localparam int CAPTURE_W         = CH_PER_CAPTURE * 8;
    localparam int WORD_W            = BYTES_PER_WORD * 8;
    localparam int TOTAL_W           = 20;

    // Captures per layer: one per pixel per group of 16 channels.
    function automatic logic [TOTAL_W-1:0] calc_total(input logic [7:0] w,
                                                      input logic [7:0] c);
        logic [15:0]        px;
        logic [TOTAL_W-1:0] groups;
        px     = {8'b0, w} * {8'b0, w};
        groups = TOTAL_W'(c) >> 4;
        return {4'b0, px} * groups;
    endfunction

    function automatic logic is_bad_cfg(input logic [7:0] w, input logic [7:0] c);
        return (c[3:0] != 4'd0) || (c == 8'd0) || (w == 8'd0);
    endfunction

endpackage

// File: rtl/ofm_capture_fifo.sv
// Small synchronous FIFO holding whole 16-channel captures until the packer
// has streamed them out; flush discards everything in one cycle.
module ofm_capture_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_wr;
    logic w_rd;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_rd = i_pop && !o_empty;
    assign w_wr = i_push && (!o_full || w_rd);

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_wr && !w_rd)      r_count <= r_count + CNT_ONE;
            else if (w_rd && !w_wr) r_count <= r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !reset && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/ofm_writeback.sv
// Collects 16-channel activation captures from the conv stage, buffers them
// and writes each one to the OFM BRAM as four consecutive 32-bit words.
module ofm_writeback
    import ofm_wb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        OFM_W,
    input  logic [7:0]        OFM_C,
    input  logic [15:0]       valid,
    input  logic [127:0]      ofm_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              cfg_err,
    output wb_state_t         o_dbg_state
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_state_t          r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [TOTAL_W-1:0] r_total;
    logic [TOTAL_W-1:0] r_cap_cnt;
    logic [1:0]         r_word;
    logic               r_done;
    logic               r_overflow;
    logic               r_cfg_err;

    logic [CAPTURE_W-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [CNT_W-1:0]     w_count;
    logic                 w_busy;
    logic                 w_drain;
    logic                 w_pop;
    logic                 w_cap;
    logic                 w_push;
    logic                 w_flush;
    logic                 w_bad_cfg;
    logic [WORD_W-1:0]    w_word;

    assign w_busy    = (r_state != IDLE);
    assign w_bad_cfg = is_bad_cfg(OFM_W, OFM_C);
    // A start always wins the cycle: no write, no capture, FIFO discarded.
    assign w_flush   = start && w_busy;
    assign w_drain   = w_busy && !w_empty && !start;
    assign w_pop     = w_drain && (r_word == 2'd3);
    assign w_cap     = (r_state == ACTIVE) && (|valid) && !start;
    assign w_push    = w_cap && (!w_full || w_pop);

    ofm_capture_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CAPTURE_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (ofm_data),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_word = w_head[31:0];
        case (r_word)
            2'd0:    w_word = w_head[31:0];
            2'd1:    w_word = w_head[63:32];
            2'd2:    w_word = w_head[95:64];
            default: w_word = w_head[127:96];
        endcase
    end

    // BRAM port is a plain write strobe: every cycle with wr_en high commits
    // wr_data at wr_addr; there is no back-pressure from the memory.
    assign wr_en       = w_drain;
    assign wr_addr     = r_addr;
    assign wr_data     = w_word;
    assign busy        = w_busy;
    assign done        = r_done;
    assign overflow    = r_overflow;
    assign cfg_err     = r_cfg_err;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_total    <= '0;
            r_cap_cnt  <= '0;
            r_word     <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_word <= '0;
                if (w_bad_cfg) begin
                    r_cfg_err <= 1'b1;
                    r_state   <= IDLE;
                end else begin
                    r_state    <= ACTIVE;
                    r_addr     <= base_addr;
                    r_total    <= calc_total(OFM_W, OFM_C);
                    r_cap_cnt  <= '0;
                    r_overflow <= 1'b0;
                    r_cfg_err  <= 1'b0;
                end
            end else begin
                if (w_drain) begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_word <= r_word + 2'd1;
                end
                case (r_state)
                    ACTIVE: begin
                        if (w_push) begin
                            r_cap_cnt <= r_cap_cnt + TOTAL_W'(1);
                            if (r_cap_cnt + TOTAL_W'(1) == r_total) r_state <= FLUSH;
                        end else if (w_cap) begin
                            r_overflow <= 1'b1;
                        end
                    end
                    FLUSH: begin
                        // Finish on the cycle the last word goes out.
                        if (w_empty || (w_pop && w_count == CNT_W'(1))) begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ofm_writeback.sv
// Directed bench for ofm_writeback: stimulus pushes expected BRAM writes into
// a queue, a negedge monitor pops and compares every write it sees.
module tb_ofm_writeback;
  import ofm_wb_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        OFM_W;
  logic [7:0]        OFM_C;
  logic [15:0]       valid;
  logic [127:0]      ofm_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              overflow;
  logic              cfg_err;
  wb_state_t         o_dbg_state;

  logic [63:0]       exp_q[$];
  logic [63:0]       mon_exp;
  logic [ADDR_W-1:0] exp_addr;
  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int w0, d0;
  logic [127:0] dd [5];
  logic [127:0] d;

  ofm_writeback #(.ADDR_W(ADDR_W), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .OFM_W       (OFM_W),
    .OFM_C       (OFM_C),
    .valid       (valid),
    .ofm_data    (ofm_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .cfg_err     (cfg_err),
    .o_dbg_state (o_dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [7:0] w, input logic [7:0] c);
    base_addr = b;
    OFM_W     = w;
    OFM_C     = c;
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
    exp_addr  = b;
  endtask

  task automatic capture(input logic [127:0] data);
    valid    = 16'h8000;
    ofm_data = data;
    tick(1);
    valid    = 16'h0000;
  endtask

  // expected words: word w carries channels 4w..4w+3, lowest channel in the low byte
  task automatic expect_words(input logic [127:0] data, input int n);
    for (int w = 0; w < n; w++) begin
      exp_q.push_back({exp_addr, data[32*w +: 32]});
      exp_addr = exp_addr + 1;
    end
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", wr_addr, wr_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("write_addr_data", {wr_addr, wr_data}, mon_exp);
        end
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; valid = '0; ofm_data = '0;
    base_addr = '0; OFM_W = '0; OFM_C = '0; exp_addr = '0;
    dd[0] = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    dd[1] = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
    dd[2] = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
    dd[3] = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;
    dd[4] = 128'hE0E1E2E3_E4E5E6E7_E8E9EAEB_ECEDEEEF;
    tick(3);

    // reset state
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_state", o_dbg_state, IDLE);
    reset = 1'b0;
    tick(1);

    // single capture, hand-computed words and latency
    do_start(32'h100, 8'd1, 8'd16);
    check("t1_busy", busy, 1);
    check("t1_state", o_dbg_state, ACTIVE);
    exp_q.push_back({32'h100, 32'h04030201});
    exp_q.push_back({32'h101, 32'h08070605});
    exp_q.push_back({32'h102, 32'h0C0B0A09});
    exp_q.push_back({32'h103, 32'h100F0E0D});
    capture(128'h100F0E0D_0C0B0A09_08070605_04030201);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_wr_en_latency", wr_en, 1);
    end
    @(negedge clk);
    check("t1_done_pulse", done, 1);
    check("t1_busy_after", busy, 0);
    @(negedge clk);
    check("t1_done_low", done, 0);
    tick(1);
    check("t1_done_cnt", done_cnt, 1);

    // full layer: 2x2 pixels, 32 channels -> 8 captures, 32 words
    w0 = wr_cnt; d0 = done_cnt;
    do_start(32'h2000, 8'd2, 8'd32);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(i * 16 + k);
      expect_words(d, 4);
      capture(d);
      tick(5);
    end
    tick(3);
    check("t2_wr_cnt", wr_cnt - w0, 32);
    check("t2_done_cnt", done_cnt - d0, 1);
    check("t2_busy", busy, 0);
    check("t2_queue_empty", exp_q.size(), 0);

    // back-to-back captures: third one overflows, no bubble in 8 words
    w0 = wr_cnt; d0 = done_cnt;
    do_start(32'h300, 8'd2, 8'd16);
    for (int i = 0; i < 3; i++) begin
      valid = 16'h0001;
      ofm_data = dd[i];
      if (i < 2) expect_words(dd[i], 4);
      @(negedge clk);
      if (i > 0) check("t3_wr_en_run", wr_en, 1);
      tick(1);
    end
    valid = '0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("t3_wr_en_run", wr_en, 1);
    end
    @(negedge clk);
    check("t3_wr_en_end", wr_en, 0);
    check("t3_overflow", overflow, 1);
    check("t3_busy", busy, 1);
    tick(1);
    expect_words(dd[3], 4);
    capture(dd[3]);
    tick(5);
    expect_words(dd[4], 4);
    capture(dd[4]);
    tick(8);
    check("t3_wr_cnt", wr_cnt - w0, 16);
    check("t3_done_cnt", done_cnt - d0, 1);
    check("t3_overflow_sticky", overflow, 1);

    // config errors
    w0 = wr_cnt;
    do_start(32'h700, 8'd1, 8'd20);
    check("t4_cfg_err_c20", cfg_err, 1);
    check("t4_busy", busy, 0);
    capture(dd[0]);
    tick(6);
    check("t4_no_writes", wr_cnt - w0, 0);
    do_start(32'h700, 8'd0, 8'd16);
    check("t4_cfg_err_w0", cfg_err, 1);
    check("t4_state", o_dbg_state, IDLE);

    // reset mid-drain after word 1
    d0 = done_cnt;
    do_start(32'h400, 8'd1, 8'd16);
    check("t5_cfg_err_cleared", cfg_err, 0);
    check("t5_overflow_cleared", overflow, 0);
    expect_words(dd[1], 2);
    capture(dd[1]);
    tick(1);
    reset = 1'b1;
    @(negedge clk);
    tick(1);
    @(negedge clk);
    check("t5_wr_en_after_reset", wr_en, 0);
    check("t5_busy_after_reset", busy, 0);
    check("t5_done_after_reset", done, 0);
    tick(1);
    reset = 1'b0;
    tick(3);
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_queue_empty", exp_q.size(), 0);

    // restart during FLUSH
    d0 = done_cnt;
    do_start(32'h500, 8'd1, 8'd16);
    expect_words(dd[2], 1);
    capture(dd[2]);
    @(negedge clk);
    check("t6_state_flush", o_dbg_state, FLUSH);
    tick(1);
    do_start(32'h600, 8'd1, 8'd16);
    @(negedge clk);
    check("t6_wr_en_after_restart", wr_en, 0);
    check("t6_busy", busy, 1);
    check("t6_state_active", o_dbg_state, ACTIVE);
    tick(1);
    expect_words(dd[3], 4);
    capture(dd[3]);
    tick(8);
    check("t6_done_cnt", done_cnt - d0, 1);
    check("t6_busy_end", busy, 0);

    // final report
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ofm_writeback.md
Name: ofm_writeback

Overview:
Consumes the 16 activated 8-bit output channels produced by the PE-cluster conv stage each time its window valid fires.
- Buffers each 16-channel capture in a 2-entry FIFO.
- Packs each capture into four 32-bit words and writes them sequentially into the OFM BRAM.
- Counts captures against the layer geometry and pulses done when the whole output feature map has been written.
- Sits directly downstream of the conv sub-top, between its OFM_active/valid outputs and the OFM memory.

Parameters:
ADDR_W, 32, width of the OFM BRAM write address.
FIFO_DEPTH, 2, number of 128-bit capture entries buffered (power of two, ≥2).

Ports:
clk  input  1  clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; loads geometry and base address and enters ACTIVE.
base_addr  input  ADDR_W  first OFM word address, sampled on start.
OFM_W  input  8  output width; the map is OFM_W×OFM_W pixels. Sampled on start.
OFM_C  input  8  output channels, a multiple of 16. Sampled on start.
valid  input  16  per-PE valid from the conv stage. A capture occurs when any bit is set.
ofm_data  input  128  packed activations; channel k at bits [8k+7:8k].
wr_en  output  1  OFM BRAM write strobe.
wr_addr  output  ADDR_W  OFM BRAM write address.
wr_data  output  32  OFM BRAM write data.
busy  output  1  high in ACTIVE or FLUSH.
done  output  1  one-cycle pulse after the last word is written.
overflow  output  1  sticky; set when a capture arrives with the FIFO full.
cfg_err  output  1  sticky; set when start sees OFM_C[3:0]≠0 or OFM_C=0 or OFM_W=0.

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, counters 0. A reset mid-operation abandons everything, with no further writes.
- Total captures expected: total = OFM_W*OFM_W*(OFM_C>>4), computed at start into a 20-bit register.
- States:
  - IDLE: valid is ignored.
    - start with good config → ACTIVE. This loads the address counter from base_addr, clears the capture count, clears overflow, and clears cfg_err.
    - start with bad config → stay IDLE and set cfg_err.
  - ACTIVE: each capture pushes ofm_data into the FIFO and increments cap_cnt.
    - When the capture that makes cap_cnt==total is accepted → FLUSH.
    - Captures beyond total do not occur in ACTIVE.
  - FLUSH: valid is ignored. When the FIFO is empty and the final word has been issued → pulse done for 1 cycle and return to IDLE.
  - start while busy: treated as a restart. The FIFO is flushed without writing, the drain is aborted, new config is loaded, and the state is ACTIVE. done does not pulse.
- Drain:
  - The head entry is emitted as 4 consecutive words, w=0..3, with wr_data = {ch[4w+3],ch[4w+2],ch[4w+1],ch[4w]}.
  - wr_addr equals the address counter, which increments by 1 per word and is never reset between pixels.
  - The entry pops in the cycle word 3 is issued. The next entry's word 0 follows in the very next cycle, with no bubble.
- Latency: with the FIFO empty, a capture at cycle N gives wr_en in cycles N+1..N+4, on consecutive addresses.
- Full: a capture with the FIFO full and no pop in the same cycle is dropped, overflow is set, and cap_cnt does not increment. A capture coinciding with a pop of the last slot is accepted.
- Address wrap: the address counter wraps modulo 2^ADDR_W silently.

Decomposition:
- Package ofm_wb_pkg:
  - state enum {IDLE, ACTIVE, FLUSH}.
  - Constants: CH_PER_CAPTURE=16, BYTES_PER_WORD=4, WORDS_PER_CAPTURE=4.
  - Function computing total from OFM_W and OFM_C.
- One sub-module: ofm_capture_fifo, a synchronous FIFO of FIFO_DEPTH×128 with push/pop/full/empty/flush.

Test Plan:
- Single capture: base_addr=0x100, OFM_W=1, OFM_C=16, ofm_data bytes k=k+1 → writes at 0x100..0x103 with data 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D in cycles N+1..N+4; done pulses at N+5.
- Full layer: OFM_W=2, OFM_C=32, captures every 6 cycles → exactly 32 writes on contiguous addresses, done once, busy low afterwards.
- Back-to-back valid on 3 consecutive cycles, FIFO_DEPTH=2:
  - first capture goes to the FIFO;
  - third capture finds the FIFO full → dropped, overflow=1;
  - 8 words are written with no bubble.
- Config error: start with OFM_C=20 → cfg_err=1, busy=0, and no writes on a subsequent valid.
- reset asserted mid-drain (after word 1) → wr_en=0 the next cycle, busy=0, and no done.
- start during FLUSH → no remaining writes from the old job, the address counter is reloaded from the new base_addr, and the new job completes normally.
